// File: rtl/game_flow_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_flow_ctrl_pkg
// Description : Shared definitions for the Arkanoid flow sequencer: state
//               encodings, screen-select flag constants, playfield geometry
//               and a state-to-screen decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package game_flow_ctrl_pkg;

    // Flow state encodings (3-bit)
    localparam logic [2:0] S_INIT = 3'd0;
    localparam logic [2:0] S_PLAY = 3'd1;
    localparam logic [2:0] S_LOST = 3'd2;
    localparam logic [2:0] S_OVER = 3'd3;
    localparam logic [2:0] S_WIN  = 3'd4;

    // Width of the VGA vertical line counter
    localparam int VCNT_W = 11;

    // Screen-select flags, ordered {init, dead, win}; at most one bit set
    localparam logic [2:0] c_SCREEN_NONE = 3'b000;
    localparam logic [2:0] c_SCREEN_INIT = 3'b100;
    localparam logic [2:0] c_SCREEN_DEAD = 3'b010;
    localparam logic [2:0] c_SCREEN_WIN  = 3'b001;

    // Playfield geometry shared with the renderer and ball/paddle logic
    localparam int TOP  = 8;
    localparam int LEFT = 8;
    localparam int MAXX = 640;
    localparam int MAXY = 480;

    // Decode a flow state into its one-hot (or empty) screen-select flags
    function automatic logic [2:0] screen_flags(input logic [2:0] state);
        case (state)
            S_INIT:  return c_SCREEN_INIT;
            S_OVER:  return c_SCREEN_DEAD;
            S_WIN:   return c_SCREEN_WIN;
            default: return c_SCREEN_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_flow_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : game_flow_ctrl_if
// Description : Bundle of the flow sequencer's game-side signals: VGA line
//               counter, button and datapath events in; screen flags, play
//               enable, lives and frame tick out.
// Revision    : 1.0 - initial release
// ============================================================================
interface game_flow_ctrl_if;
    import game_flow_ctrl_pkg::*;

    logic [VCNT_W-1:0] vcounter;
    logic              btn_start;
    logic              ball_lost;
    logic              bricks_cleared;
    logic              init;
    logic              dead;
    logic              win;
    logic              play_en;
    logic [2:0]        lives;
    logic              frame_tick;

    // Side that supplies timing/events and consumes the flow outputs
    modport master (
        output vcounter, btn_start, ball_lost, bricks_cleared,
        input  init, dead, win, play_en, lives, frame_tick
    );

    // The flow sequencer itself
    modport slave (
        input  vcounter, btn_start, ball_lost, bricks_cleared,
        output init, dead, win, play_en, lives, frame_tick
    );

endinterface
`default_nettype wire

// File: rtl/game_flow_ctrl_frame_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : game_flow_ctrl_frame_tick_gen
// Description : Detects the VGA vertical counter wrapping to zero and emits a
//               registered one-cycle frame_tick. Reusable by any logic that
//               paces itself in frames.
// Revision    : 1.0 - initial release
// ============================================================================
module game_flow_ctrl_frame_tick_gen #(
    parameter int VCNT_W = 11
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic [VCNT_W-1:0] vcounter,
    output logic                   frame_tick
);

    logic [VCNT_W-1:0] r_vcounter_q;
    logic              r_frame_tick;
    logic              w_wrap;

    // A frame starts when the counter sits at 0 but did not last cycle, so a
    // counter parked at 0 yields only one pulse.
    assign w_wrap = (vcounter == '0) && (r_vcounter_q != '0);

    // Remember the previous line count and register the wrap pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vcounter_q <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_vcounter_q <= vcounter;
            r_frame_tick <= w_wrap;
        end
    end

    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_flow_ctrl
// Description : Arkanoid screen/flow sequencer. Selects title, game-over and
//               win screens, enables ball/paddle motion, tracks lives and
//               times the respawn pause and game-over hold in frames.
// Config      : define WIN_SCREEN_EN to build the win screen; otherwise
//               bricks_cleared is ignored and win is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module game_flow_ctrl
    import game_flow_ctrl_pkg::*;
#(
    parameter int LIVES          = 3,
    parameter int RESPAWN_FRAMES = 60,
    parameter int OVER_FRAMES    = 180,
    parameter int CNT_W          = 8
) (
    input wire logic        clk,
    input wire logic        rst_n,
    game_flow_ctrl_if.slave bus
);

    localparam logic [2:0]       c_LIVES   = 3'(LIVES);
    localparam logic [CNT_W-1:0] c_RESPAWN = CNT_W'(RESPAWN_FRAMES);
    localparam logic [CNT_W-1:0] c_OVER    = CNT_W'(OVER_FRAMES);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [2:0]       r_lives;
    logic [2:0]       w_lives_nxt;
    logic [CNT_W-1:0] r_countdown;
    logic [CNT_W-1:0] w_countdown_nxt;
    logic [CNT_W-1:0] w_countdown_dec;
    logic             r_btn_q;
    logic             w_start_rise;
    logic [2:0]       r_screen;
    logic             r_play_en;
    logic             w_frame_tick;

    game_flow_ctrl_frame_tick_gen #(
        .VCNT_W (VCNT_W)
    ) u_frame_tick_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .vcounter   (bus.vcounter),
        .frame_tick (w_frame_tick)
    );

    // A held button counts once: only the 0->1 transition is an event
    assign w_start_rise = bus.btn_start & ~r_btn_q;

    // The frame countdown saturates at zero rather than wrapping
    assign w_countdown_dec = (r_countdown != '0) ? (r_countdown - c_ONE) : '0;

    // Next-state, lives and countdown decode
    always_comb begin
        w_state_nxt     = r_state;
        w_lives_nxt     = r_lives;
        w_countdown_nxt = r_countdown;
        case (r_state)
            S_INIT: begin
                if (w_start_rise) begin
                    w_state_nxt = S_PLAY;
                    w_lives_nxt = c_LIVES;
                end
            end
            S_PLAY: begin
                // A lost ball outranks a cleared wall in the same cycle
                if (bus.ball_lost) begin
                    if (r_lives > 3'd1) begin
                        w_lives_nxt     = r_lives - 3'd1;
                        w_countdown_nxt = c_RESPAWN;
                        w_state_nxt     = S_LOST;
                    end else begin
                        w_lives_nxt     = 3'd0;
                        w_countdown_nxt = c_OVER;
                        w_state_nxt     = S_OVER;
                    end
                end
`ifdef WIN_SCREEN_EN
                else if (bus.bricks_cleared) begin
                    w_state_nxt = S_WIN;
                end
`endif
            end
            S_LOST: begin
                // Resume as the last pause frame is consumed
                if (r_countdown == '0) begin
                    w_state_nxt = S_PLAY;
                end else if (w_frame_tick) begin
                    w_countdown_nxt = w_countdown_dec;
                    if (r_countdown == c_ONE) begin
                        w_state_nxt = S_PLAY;
                    end
                end
            end
            S_OVER: begin
                // Start is only honoured once the hold has fully elapsed
                if (w_start_rise && (r_countdown == '0)) begin
                    w_state_nxt = S_INIT;
                end else if (w_frame_tick) begin
                    w_countdown_nxt = w_countdown_dec;
                end
            end
`ifdef WIN_SCREEN_EN
            S_WIN: begin
                if (w_start_rise) begin
                    w_state_nxt = S_INIT;
                end
            end
`endif
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    // State, counters and outputs; outputs decode the upcoming state so they
    // change on the same edge as the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_INIT;
            r_lives     <= c_LIVES;
            r_countdown <= '0;
            r_btn_q     <= 1'b0;
            r_screen    <= c_SCREEN_INIT;
            r_play_en   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lives     <= w_lives_nxt;
            r_countdown <= w_countdown_nxt;
            r_btn_q     <= bus.btn_start;
            r_screen    <= screen_flags(w_state_nxt);
            r_play_en   <= (w_state_nxt == S_PLAY);
        end
    end

    assign bus.init       = r_screen[2];
    assign bus.dead       = r_screen[1];
    assign bus.play_en    = r_play_en;
    assign bus.lives      = r_lives;
    assign bus.frame_tick = w_frame_tick;

`ifdef WIN_SCREEN_EN
    assign bus.win = r_screen[0];
`else
    // Without the win screen, bricks_cleared and the win flag bit go nowhere
    logic [1:0] w_unused_win;
    assign w_unused_win = {bus.bricks_cleared, r_screen[0]};
    assign bus.win      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_flow_ctrl
// Description : Self-checking bench for game_flow_ctrl: directed vector table,
//               hand-written frame-count corner cases and randomized play
//               checked cycle by cycle against a behavioural game model.
//               Honours WIN_SCREEN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_flow_ctrl;

    localparam int LIVES = 3;
    localparam int RESP  = 60;
    localparam int OVER  = 180;
`ifdef WIN_SCREEN_EN
    localparam bit WIN_ON = 1'b1;
`else
    localparam bit WIN_ON = 1'b0;
`endif

    // Game phases as the player sees them
    localparam int M_TITLE = 0;
    localparam int M_PLAY  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_OVER  = 3;
    localparam int M_WIN   = 4;

    typedef struct {
        bit         btn;
        bit         lost;
        bit         bricks;
        int         cycles;
        logic [6:0] exp;     // {init, dead, win, play_en, lives}
    } vec_t;

    logic clk;
    logic rst_n;

    game_flow_ctrl_if bus ();

    game_flow_ctrl #(
        .LIVES          (LIVES),
        .RESPAWN_FRAMES (RESP),
        .OVER_FRAMES    (OVER),
        .CNT_W          (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total;
    int          bad;
    int          m_mode;
    int          m_lives;
    int          m_left;
    bit          m_tick;
    bit          m_btn_prev;
    logic [10:0] m_vc_prev;
    logic [10:0] vc_val;
    logic [10:0] vc_max;
    vec_t        vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_out();
        return {bus.init, bus.dead, bus.win, bus.play_en, bus.lives, bus.frame_tick};
    endfunction

    function automatic logic [7:0] model_out();
        logic [2:0] l;
        l = 3'(m_lives);
        return {m_mode == M_TITLE, m_mode == M_OVER, m_mode == M_WIN,
                m_mode == M_PLAY, l, m_tick};
    endfunction

    task automatic model_reset();
        m_mode     = M_TITLE;
        m_lives    = LIVES;
        m_left     = 0;
        m_tick     = 1'b0;
        m_btn_prev = 1'b0;
        m_vc_prev  = '0;
    endtask

    // One clock of the game rules, given this cycle's inputs
    task automatic model_update(input bit b, input bit l, input bit k, input logic [10:0] vc);
        bit press;
        bit new_frame;
        press     = b && !m_btn_prev;
        new_frame = m_tick;
        case (m_mode)
            M_TITLE: if (press) begin
                m_mode  = M_PLAY;
                m_lives = LIVES;
            end
            M_PLAY: begin
                if (l) begin
                    if (m_lives > 1) begin
                        m_lives = m_lives - 1;
                        m_left  = RESP;
                        m_mode  = M_PAUSE;
                    end else begin
                        m_lives = 0;
                        m_left  = OVER;
                        m_mode  = M_OVER;
                    end
                end else if (WIN_ON && k) begin
                    m_mode = M_WIN;
                end
            end
            M_PAUSE: if (new_frame) begin
                m_left = m_left - 1;
                if (m_left == 0) m_mode = M_PLAY;
            end
            M_OVER: begin
                if (press && m_left == 0) m_mode = M_TITLE;
                else if (new_frame && m_left > 0) m_left = m_left - 1;
            end
            M_WIN: if (press) m_mode = M_TITLE;
            default: m_mode = M_TITLE;
        endcase
        m_tick     = (vc == 11'd0) && (m_vc_prev != 11'd0);
        m_vc_prev  = vc;
        m_btn_prev = b;
    endtask

    // Apply one cycle of inputs, advance the model, compare after the edge
    task automatic cycle(input bit b, input bit l, input bit k);
        vc_val             = (vc_val >= vc_max) ? 11'd0 : vc_val + 11'd1;
        bus.btn_start      = b;
        bus.ball_lost      = l;
        bus.bricks_cleared = k;
        bus.vcounter       = vc_val;
        model_update(b, l, k, vc_val);
        @(negedge clk);
        check("model", {24'd0, dut_out()}, {24'd0, model_out()});
    endtask

    task automatic add_vec(input bit b, input bit l, input bit k, input int n, input logic [6:0] e);
        vec_t v;
        v.btn = b; v.lost = l; v.bricks = k; v.cycles = n; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        int n;
        int guard;
        int ticks;
        bit rb;

        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        bus.btn_start      = 1'b0;
        bus.ball_lost      = 1'b0;
        bus.bricks_cleared = 1'b0;
        bus.vcounter       = '0;
        vc_val = '0;
        vc_max = 11'd3;
        model_reset();

        // Asynchronous reset takes effect before any clock edge
        #1 rst_n = 1'b0;
        #2 check("reset_async", {24'd0, dut_out()}, 32'h86);
        @(negedge clk);
        @(negedge clk);
        check("reset_held", {24'd0, dut_out()}, 32'h86);
        rst_n = 1'b1;

        // ---------------- directed vector table ----------------
        add_vec(1, 0, 0, 1,   7'b0001_011);   // start
        add_vec(1, 0, 0, 5,   7'b0001_011);   // held button: no new event
        add_vec(0, 1, 0, 1,   7'b0000_010);   // lose a ball
        add_vec(0, 0, 0, 20,  7'b0000_010);   // still paused
        add_vec(0, 0, 0, 300, 7'b0001_010);   // respawned
`ifdef WIN_SCREEN_EN
        add_vec(0, 0, 1, 1,   7'b0010_010);   // wall cleared -> win
        add_vec(1, 0, 0, 1,   7'b1000_010);   // start -> title
        add_vec(0, 0, 0, 1,   7'b1000_010);
        add_vec(1, 0, 0, 1,   7'b0001_011);   // new game
        add_vec(0, 1, 1, 1,   7'b0000_010);   // lost beats cleared
        add_vec(0, 0, 0, 300, 7'b0001_010);
`else
        add_vec(0, 0, 1, 40,  7'b0001_010);   // cleared wall ignored
        add_vec(0, 1, 0, 1,   7'b0000_001);
        add_vec(0, 0, 0, 300, 7'b0001_001);
        add_vec(0, 1, 0, 1,   7'b0100_000);   // last life -> game over
        add_vec(0, 0, 0, 40,  7'b0100_000);
        add_vec(1, 0, 0, 1,   7'b0100_000);   // early start ignored
        add_vec(0, 0, 0, 800, 7'b0100_000);
        add_vec(1, 0, 0, 1,   7'b1000_000);   // hold elapsed -> title
        add_vec(0, 0, 0, 1,   7'b1000_000);
        add_vec(1, 0, 0, 1,   7'b0001_011);
        add_vec(0, 0, 0, 1,   7'b0001_011);
`endif
        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].cycles; c++) cycle(vecs[i].btn, vecs[i].lost, vecs[i].bricks);
            check($sformatf("vec%0d", i),
                  {25'd0, bus.init, bus.dead, bus.win, bus.play_en, bus.lives}, {25'd0, vecs[i].exp});
        end

        // ---------------- respawn lasts exactly RESP frames ----------------
        cycle(0, 1, 0);
        n = m_tick;
        guard = 0;
        while (n < RESP && guard < 2000) begin
            check("respawn_paused", {31'd0, bus.play_en}, 32'd0);
            cycle(0, 0, 0);
            n += m_tick;
            guard++;
        end
        check("respawn_budget", guard < 2000, 1);
        check("respawn_last_frame", {31'd0, bus.play_en}, 32'd0);
        cycle(0, 0, 0);
        check("respawn_done", {31'd0, bus.play_en}, 32'd1);

        // ---------------- game-over hold ----------------
        guard = 0;
        while (m_lives > 1 && guard < 10) begin
            cycle(0, 1, 0);
            repeat (300) cycle(0, 0, 0);
            guard++;
        end
        cycle(0, 1, 0);
        check("over_entered", {30'd0, bus.dead, bus.lives == 3'd0}, 32'd3);
        n = m_tick;
        guard = 0;
        while (n < 100 && guard < 2000) begin cycle(0, 0, 0); n += m_tick; guard++; end
        cycle(1, 0, 0);
        n += m_tick;
        check("over_frame100_start", {30'd0, bus.init, bus.dead}, 32'd1);
        guard = 0;
        while (n < OVER && guard < 2000) begin cycle(0, 0, 0); n += m_tick; guard++; end
        check("over_budget", guard < 2000, 1);
        cycle(1, 0, 0);                       // final frame still counting
        check("over_last_frame_start", {30'd0, bus.init, bus.dead}, 32'd1);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        check("over_release", {30'd0, bus.init, bus.dead}, 32'd2);

        // ---------------- reset mid-pause ----------------
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        n = m_tick;
        while (n < 30) begin cycle(0, 0, 0); n += m_tick; end
        check("pre_reset_paused", {31'd0, bus.play_en}, 32'd0);
        #2 rst_n = 1'b0;
        #1 check("reset_mid_pause", {24'd0, dut_out()}, 32'h86);
        model_reset();
        @(negedge clk);
        check("reset_mid_pause_held", {24'd0, dut_out()}, 32'h86);
        rst_n = 1'b1;

        // ---------------- vcounter wrap edge ----------------
        vc_max = 11'd524;
        vc_val = 11'd519;
        ticks  = 0;
        repeat (12) begin cycle(0, 0, 0); ticks += bus.frame_tick; end
        check("wrap_524_single_tick", ticks, 1);
        vc_max = 11'd0;                       // counter parks at 0
        ticks  = 0;
        repeat (8) begin cycle(0, 0, 0); ticks += bus.frame_tick; end
        check("parked_zero_single_tick", ticks, 1);

        // ---------------- randomized play ----------------
        vc_max = 11'($urandom_range(2, 4));
        rb = 1'b0;
        repeat (4000) begin
            if ($urandom_range(0, 15) == 0) rb = ~rb;
            cycle(rb, $urandom_range(0, 79) == 0, $urandom_range(0, 149) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
